// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM capture block: FSM state encoding and duty width.
// The duty width matches the one used by the PWM generator.
package pwm_capture_pkg;

    localparam int DUTY_W = 8;

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

endpackage

// File: rtl/pwm_capture_edge_sync.sv
// Two-flop synchronizer plus registered edge detector for an asynchronous pin input.
// The synchronizer flops carry data only and are not reset, so a reset never fabricates an edge.
module pwm_edge_sync (
    input  logic clk_in,
    input  logic rst_in,
    input  logic async_in,
    output logic lvl_out,
    output logic rise_out,
    output logic fall_out
);

    logic r_sync_p0;
    logic r_sync_p1;
    logic r_lvl_p2;
    logic r_rise_p2;
    logic r_fall_p2;

    // p0/p1: metastability filter; p2: previous level and registered edge strobes
    always_ff @(posedge clk_in) begin
        r_sync_p0 <= async_in;
        r_sync_p1 <= r_sync_p0;
        r_lvl_p2  <= r_sync_p1;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_rise_p2 <= 1'b0;
            r_fall_p2 <= 1'b0;
        end else begin
            r_rise_p2 <= r_sync_p1 & ~r_lvl_p2;
            r_fall_p2 <= ~r_sync_p1 & r_lvl_p2;
        end
    end

    assign lvl_out  = r_lvl_p2;
    assign rise_out = r_rise_p2;
    assign fall_out = r_fall_p2;

endmodule

// File: rtl/pwm_capture.sv
// Measures an incoming PWM waveform: high time, period and 8-bit duty per frame,
// plus stuck-low / stuck-high detection when the input stops toggling.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty_out,
    output logic [CNT_W-1:0]  high_out,
    output logic [CNT_W-1:0]  period_out,
    output logic              valid_out,
    output logic              stuck_lo_out,
    output logic              stuck_hi_out
);

    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  DUTY_CAP  = CNT_W'(2**DUTY_W - 1);
    localparam logic [CNT_W-1:0]  IDLE_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  IDLE_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [DUTY_W-1:0] DUTY_FULL = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_ONE;
    endfunction

    function automatic logic [DUTY_W-1:0] sat_duty(input logic [CNT_W-1:0] v);
        return (v > DUTY_CAP) ? DUTY_FULL : v[DUTY_W-1:0];
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_high_cnt;
    logic [CNT_W-1:0] r_period_cnt;
    logic [CNT_W-1:0] r_idle_cnt;

    logic w_lvl;
    logic w_rise;
    logic w_fall;
    logic w_edge;
    logic w_timeout;
    logic w_publish;
    logic w_restart;

    pwm_edge_sync u_edge_sync (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .async_in (pwm_in),
        .lvl_out  (w_lvl),
        .rise_out (w_rise),
        .fall_out (w_fall)
    );

    assign w_edge = w_rise | w_fall;

    // An edge in the same cycle as the timeout wins, so the flag never rises with it.
    assign w_timeout = ~w_edge & (r_idle_cnt == IDLE_LAST);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= S_WAIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_timeout) begin
            w_state_nxt = S_WAIT;
        end else begin
            case (r_state)
                S_WAIT:  if (w_rise) w_state_nxt = S_HIGH;
                S_HIGH:  if (w_fall) w_state_nxt = S_LOW;
                S_LOW:   if (w_rise) w_state_nxt = S_HIGH;
                default: w_state_nxt = S_WAIT;
            endcase
        end
    end

    always_comb begin
        w_publish = 1'b0;
        w_restart = 1'b0;
        if (!w_timeout) begin
            case (r_state)
                S_WAIT: w_restart = w_rise;
                S_LOW: begin
                    w_publish = w_rise;
                    w_restart = w_rise;
                end
                default: begin
                    w_publish = 1'b0;
                    w_restart = 1'b0;
                end
            endcase
        end
    end

    // The rise cycle counts as high cycle 1, hence the restart value of 1.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_high_cnt   <= '0;
            r_period_cnt <= '0;
        end else if (w_restart) begin
            r_high_cnt   <= CNT_ONE;
            r_period_cnt <= CNT_ONE;
        end else if (r_state == S_HIGH) begin
            r_period_cnt <= sat_inc(r_period_cnt);
            if (!w_fall) begin
                r_high_cnt <= sat_inc(r_high_cnt);
            end
        end else if (r_state == S_LOW) begin
            r_period_cnt <= sat_inc(r_period_cnt);
        end
    end

    // Idle counter parks at TIMEOUT so a long stuck period strobes only once.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_idle_cnt <= '0;
        end else if (w_edge) begin
            r_idle_cnt <= '0;
        end else if (r_idle_cnt != IDLE_MAX) begin
            r_idle_cnt <= r_idle_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            duty_out     <= '0;
            high_out     <= '0;
            period_out   <= '0;
            valid_out    <= 1'b0;
            stuck_lo_out <= 1'b0;
            stuck_hi_out <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            if (w_edge) begin
                stuck_lo_out <= 1'b0;
                stuck_hi_out <= 1'b0;
            end
            if (w_publish) begin
                high_out   <= r_high_cnt;
                period_out <= r_period_cnt;
                duty_out   <= sat_duty(r_high_cnt);
                valid_out  <= 1'b1;
            end else if (w_timeout) begin
                high_out     <= '0;
                period_out   <= '0;
                duty_out     <= w_lvl ? DUTY_FULL : '0;
                stuck_lo_out <= ~w_lvl;
                stuck_hi_out <= w_lvl;
                valid_out    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: a PWM frame generator feeds the DUT, expected
// publications are queued ahead of the stimulus, and a monitor checks every strobe.
`timescale 1ns/1ps
module tb_pwm_capture;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 1024;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic             pwm_in;
    logic [7:0]       duty_out;
    logic [CNT_W-1:0] high_out;
    logic [CNT_W-1:0] period_out;
    logic             valid_out;
    logic             stuck_lo_out;
    logic             stuck_hi_out;

    typedef struct packed {
        logic [7:0]  duty;
        logic [15:0] high;
        logic [15:0] period;
        logic        slo;
        logic        shi;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    logic prev_valid = 1'b0;

    pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .pwm_in       (pwm_in),
        .duty_out     (duty_out),
        .high_out     (high_out),
        .period_out   (period_out),
        .valid_out    (valid_out),
        .stuck_lo_out (stuck_lo_out),
        .stuck_hi_out (stuck_hi_out)
    );

    always #5 clk_in = ~clk_in;

    // Monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk_in) begin
        if (valid_out) begin
            if (prev_valid) begin
                checks++;
                failures++;
                $display("FAIL valid_back_to_back actual=1 required=0 at %0t", $time);
            end
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_strobe actual duty=%0d high=%0d period=%0d slo=%0b shi=%0b required=no strobe",
                         duty_out, high_out, period_out, stuck_lo_out, stuck_hi_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (duty_out !== e.duty || high_out !== e.high || period_out !== e.period ||
                    stuck_lo_out !== e.slo || stuck_hi_out !== e.shi) begin
                    failures++;
                    $display("FAIL strobe actual duty=%0d high=%0d period=%0d slo=%0b shi=%0b required duty=%0d high=%0d period=%0d slo=%0b shi=%0b",
                             duty_out, high_out, period_out, stuck_lo_out, stuck_hi_out,
                             e.duty, e.high, e.period, e.slo, e.shi);
                end
            end
        end
        prev_valid = valid_out;
    end

    task automatic check_val(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push_exp(input int duty, input int high, input int period, input bit slo, input bit shi);
        exp_t e;
        e.duty   = 8'(duty);
        e.high   = 16'(high);
        e.period = 16'(period);
        e.slo    = slo;
        e.shi    = shi;
        exp_q.push_back(e);
    endtask

    task automatic push_frame(input int x);
        push_exp(x, x, 256, 1'b0, 1'b0);
    endtask

    task automatic tick_drive(input bit v);
        @(posedge clk_in);
        #1;
        pwm_in = v;
    endtask

    task automatic run_frames(input int x, input int n);
        for (int f = 0; f < n; f++) begin
            for (int c = 0; c < 256; c++) begin
                tick_drive(c < x);
            end
        end
    endtask

    task automatic hold(input bit v, input int n);
        for (int i = 0; i < n; i++) begin
            tick_drive(v);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_duty"},   duty_out,     0);
        check_val({tag, "_high"},   high_out,     0);
        check_val({tag, "_period"}, period_out,   0);
        check_val({tag, "_valid"},  valid_out,    0);
        check_val({tag, "_slo"},    stuck_lo_out, 0);
        check_val({tag, "_shi"},    stuck_hi_out, 0);
    endtask

    initial begin
        rst_in = 1'b1;
        pwm_in = 1'b0;
        repeat (5) @(posedge clk_in);
        #1 rst_in = 1'b0;
        @(posedge clk_in);
        #1;
        check_all_zero("reset");

        // x=64: first rise only arms the FSM, then one publish per frame start.
        repeat (3) push_frame(64);
        run_frames(64, 4);

        // The first rise of a new setting still closes the last frame of the old one.
        push_frame(64);
        repeat (2) push_frame(1);
        run_frames(1, 3);

        push_frame(1);
        repeat (2) push_frame(255);
        run_frames(255, 3);

        // Setpoint change 64 -> 200 mid-stream.
        push_frame(255);
        push_frame(64);
        run_frames(64, 2);
        push_frame(64);
        repeat (2) push_frame(200);
        run_frames(200, 3);

        // Dead input low: one stuck-low strobe, then silence.
        push_exp(0, 0, 0, 1'b1, 1'b0);
        hold(1'b0, 6100);
        check_val("stuck_lo_held", stuck_lo_out, 1);
        check_val("stuck_lo_shi",  stuck_hi_out, 0);
        check_val("stuck_lo_duty", duty_out,     0);

        // Dead input high: the rise clears stuck-low, timeout then flags stuck-high.
        push_exp(255, 0, 0, 1'b0, 1'b1);
        hold(1'b1, 2000);
        check_val("stuck_hi_held", stuck_hi_out, 1);
        check_val("stuck_hi_slo",  stuck_lo_out, 0);
        check_val("stuck_hi_duty", duty_out,     255);

        // Resume at x=128: first fall clears the flag, first full frame reports 128.
        repeat (2) push_frame(128);
        run_frames(128, 1);
        check_val("stuck_hi_cleared", stuck_hi_out, 0);
        run_frames(128, 3);

        // Reset in the high phase of an x=64 frame.
        push_frame(128);
        for (int c = 0; c < 30; c++) begin
            tick_drive(c < 64);
        end
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        pwm_in = 1'b1;
        @(posedge clk_in);
        #1;
        check_all_zero("midreset");
        rst_in = 1'b0;
        pwm_in = 1'b1;
        for (int c = 32; c < 256; c++) begin
            tick_drive(c < 64);
        end
        repeat (2) push_frame(64);
        run_frames(64, 3);
        hold(1'b0, 10);

        check_val("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
